gprs_operand_fetch: RTL and testbench

Operand-fetch initiator for the 8×16 general-purpose register file. It accepts decoded instructions from decode and drives the register file's read addresses and write port. It tracks pending writebacks in an 8-bit scoreboard, bypasses same-cycle writeback data, and stalls on hazards. Resolved operands are held in one registered stage toward execute.

---
 rtl/gprs_pkg.sv | 11 +
 rtl/gprs_scoreboard.sv | 39 +++
 rtl/gprs_operand_fetch.sv | 111 +++++++++++
 tb/tb_gprs_operand_fetch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gprs_pkg.sv
// Shared constants and types for the GPR operand-fetch slice.
package gprs_pkg;
   localparam int DATA_W = 16;
   localparam int NREG   = 8;
   localparam int AW     = $clog2(NREG);

   typedef logic [AW-1:0]     reg_idx_t;
   typedef logic [DATA_W-1:0] word_t;

   typedef enum logic {ST_EMPTY, ST_FULL} ostate_t;
endpackage

// File: rtl/gprs_scoreboard.sv
// Pending-writeback scoreboard with two source lookups and one dest lookup.
module gprs_scoreboard #(
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          set_en,
   input  logic [AW-1:0] set_idx,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_idx,
   input  logic [AW-1:0] rd1_idx,
   input  logic [AW-1:0] rd2_idx,
   input  logic [AW-1:0] ws_idx,
   output logic          busy_rd1,
   output logic          busy_rd2,
   output logic          busy_ws
);
   logic [NREG-1:0] busy;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en) set_mask[set_idx] = 1'b1;
      if (clr_en) clr_mask[clr_idx] = 1'b1;
   end

   // set applied after clear so a new writer wins over a retiring one
   always_ff @(posedge clk) begin
      if (reset) busy <= '0;
      else       busy <= (busy & ~clr_mask) | set_mask;
   end

   assign busy_rd1 = busy[rd1_idx];
   assign busy_rd2 = busy[rd2_idx];
   assign busy_ws  = busy[ws_idx];
endmodule

// File: rtl/gprs_operand_fetch.sv
// Operand fetch: RF addressing, writeback bypass, hazard stall, output stage.
module gprs_operand_fetch #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int AW     = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dec_valid,
   output logic              dec_ready,
   input  logic [AW-1:0]     dec_rs1,
   input  logic [AW-1:0]     dec_rs2,
   input  logic              dec_use_rs1,
   input  logic              dec_use_rs2,
   input  logic              dec_wr_en,
   input  logic [AW-1:0]     dec_ws,
   output logic [AW-1:0]     rf_rs1,
   output logic [AW-1:0]     rf_rs2,
   input  logic [DATA_W-1:0] rf_rd1,
   input  logic [DATA_W-1:0] rf_rd2,
   output logic              rf_we,
   output logic [AW-1:0]     rf_ws,
   output logic [DATA_W-1:0] rf_wd,
   input  logic              wb_valid,
   input  logic [AW-1:0]     wb_ws,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [DATA_W-1:0] ex_op1,
   output logic [DATA_W-1:0] ex_op2,
   output logic              ex_wr_en,
   output logic [AW-1:0]     ex_ws,
   output logic [15:0]       stall_cnt
);
   import gprs_pkg::*;

   logic              byp1, byp2, byp_ws;
   logic              busy_rs1, busy_rs2, busy_ws;
   logic              raw1, raw2, waw, accept;
   logic [DATA_W-1:0] op1, op2;
   ostate_t           state;

   assign rf_rs1 = dec_rs1;
   assign rf_rs2 = dec_rs2;
   assign rf_we  = wb_valid & ~reset;
   assign rf_ws  = wb_ws;
   assign rf_wd  = wb_data;

   assign byp1   = wb_valid & (wb_ws == dec_rs1);
   assign byp2   = wb_valid & (wb_ws == dec_rs2);
   assign byp_ws = wb_valid & (wb_ws == dec_ws);
   assign op1    = byp1 ? wb_data : rf_rd1;
   assign op2    = byp2 ? wb_data : rf_rd2;

   assign raw1 = dec_use_rs1 & busy_rs1 & ~byp1;
   assign raw2 = dec_use_rs2 & busy_rs2 & ~byp2;
   assign waw  = dec_wr_en & busy_ws & ~byp_ws;

   assign dec_ready = (~ex_valid | ex_ready) & ~raw1 & ~raw2 & ~waw;
   assign accept    = dec_valid & dec_ready;

   gprs_scoreboard #(.NREG(NREG), .AW(AW)) u_sb (
      .clk      (clk),
      .reset    (reset),
      .set_en   (accept & dec_wr_en),
      .set_idx  (dec_ws),
      .clr_en   (wb_valid),
      .clr_idx  (wb_ws),
      .rd1_idx  (dec_rs1),
      .rd2_idx  (dec_rs2),
      .ws_idx   (dec_ws),
      .busy_rd1 (busy_rs1),
      .busy_rd2 (busy_rs2),
      .busy_ws  (busy_ws)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_EMPTY;
         ex_valid <= 1'b0;
         ex_op1   <= '0;
         ex_op2   <= '0;
         ex_wr_en <= 1'b0;
         ex_ws    <= '0;
      end else begin
         if (accept) begin
            ex_op1   <= op1;
            ex_op2   <= op2;
            ex_wr_en <= dec_wr_en;
            ex_ws    <= dec_ws;
         end
         unique case (state)
            ST_EMPTY: if (accept) begin
               state    <= ST_FULL;
               ex_valid <= 1'b1;
            end
            ST_FULL: if (!accept && ex_ready) begin
               state    <= ST_EMPTY;
               ex_valid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         stall_cnt <= '0;
      else if (dec_valid && !dec_ready && !(&stall_cnt))
         stall_cnt <= stall_cnt + 16'd1;
   end
endmodule

// File: tb/tb_gprs_operand_fetch.sv
// Randomized + directed bench for gprs_operand_fetch against a behavioural model.
module tb_gprs_operand_fetch;
   import gprs_pkg::*;

   logic     clk = 1'b0;
   logic     reset;
   logic     dec_valid, dec_ready;
   reg_idx_t dec_rs1, dec_rs2, dec_ws;
   logic     dec_use_rs1, dec_use_rs2, dec_wr_en;
   reg_idx_t rf_rs1, rf_rs2, rf_ws;
   word_t    rf_rd1, rf_rd2, rf_wd;
   logic     rf_we;
   logic     wb_valid;
   reg_idx_t wb_ws;
   word_t    wb_data;
   logic     ex_valid, ex_ready, ex_wr_en;
   word_t    ex_op1, ex_op2;
   reg_idx_t ex_ws;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   gprs_operand_fetch #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW)) dut (
      .clk(clk), .reset(reset),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
      .dec_wr_en(dec_wr_en), .dec_ws(dec_ws),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
      .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .rf_we(rf_we), .rf_ws(rf_ws), .rf_wd(rf_wd),
      .wb_valid(wb_valid), .wb_ws(wb_ws), .wb_data(wb_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_op1(ex_op1), .ex_op2(ex_op2),
      .ex_wr_en(ex_wr_en), .ex_ws(ex_ws),
      .stall_cnt(stall_cnt)
   );

   // external register file, written only through the DUT's write port
   word_t rf_arr [NREG];
   assign rf_rd1 = rf_arr[rf_rs1];
   assign rf_rd2 = rf_arr[rf_rs2];
   always @(posedge clk) if (rf_we) rf_arr[rf_ws] <= rf_wd;

   // reference model state
   bit       m_busy [NREG];
   word_t    m_rf   [NREG];
   bit       m_valid, m_wr, m_acc;
   word_t    m_op1, m_op2;
   reg_idx_t m_ws;
   int       m_cnt;
   int       n_cmp, n_err;
   word_t    hold1, hold2;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic dec(bit v, int r1, bit u1, int r2, bit u2, bit we, int ws);
      dec_valid = v;
      dec_rs1 = 3'(r1); dec_use_rs1 = u1;
      dec_rs2 = 3'(r2); dec_use_rs2 = u2;
      dec_wr_en = we; dec_ws = 3'(ws);
   endtask

   task automatic wb(bit v, int ws, int d);
      wb_valid = v; wb_ws = 3'(ws); wb_data = 16'(d);
   endtask

   task automatic cycle();
      bit b1, b2, bw, rdy;
      word_t o1, o2;
      #1;
      b1 = wb_valid && (wb_ws == dec_rs1);
      b2 = wb_valid && (wb_ws == dec_rs2);
      bw = wb_valid && (wb_ws == dec_ws);
      o1 = b1 ? wb_data : m_rf[dec_rs1];
      o2 = b2 ? wb_data : m_rf[dec_rs2];
      rdy = !(m_valid && !ex_ready)
         && !(dec_use_rs1 && m_busy[dec_rs1] && !b1)
         && !(dec_use_rs2 && m_busy[dec_rs2] && !b2)
         && !(dec_wr_en && m_busy[dec_ws] && !bw);
      chk("dec_ready", dec_ready, rdy);
      chk("rf_we", rf_we, wb_valid && !reset);
      if (wb_valid && !reset) begin
         chk("rf_ws", rf_ws, wb_ws);
         chk("rf_wd", rf_wd, wb_data);
      end
      chk("rf_raddr", {rf_rs1, rf_rs2}, {dec_rs1, dec_rs2});
      m_acc = dec_valid && rdy && !reset;
      @(posedge clk);
      if (reset) begin
         foreach (m_busy[i]) m_busy[i] = 0;
         m_valid = 0; m_op1 = 0; m_op2 = 0; m_wr = 0; m_ws = 0; m_cnt = 0;
      end else begin
         if (dec_valid && !rdy && m_cnt < 65535) m_cnt++;
         if (wb_valid) begin
            m_rf[wb_ws] = wb_data;
            m_busy[wb_ws] = 0;
         end
         if (m_acc) begin
            m_valid = 1; m_op1 = o1; m_op2 = o2;
            m_wr = dec_wr_en; m_ws = dec_ws;
            if (dec_wr_en) m_busy[dec_ws] = 1;
         end else if (ex_ready) begin
            m_valid = 0;
         end
      end
      #1;
      chk("ex_valid", ex_valid, m_valid);
      chk("ex_op1", ex_op1, m_op1);
      chk("ex_op2", ex_op2, m_op2);
      chk("ex_wr_en", ex_wr_en, m_wr);
      chk("ex_ws", ex_ws, m_ws);
      chk("stall_cnt", stall_cnt, 32'(m_cnt));
   endtask

   task automatic clear_busy();
      dec(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < NREG; i++) begin
         wb(1, i, $urandom);
         cycle();
      end
      wb(0, 0, 0);
   endtask

   initial begin
      n_cmp = 0; n_err = 0; m_cnt = 0;
      m_valid = 0; m_wr = 0; m_ws = 0; m_op1 = 0; m_op2 = 0; m_acc = 0;
      foreach (m_rf[i]) begin m_rf[i] = 0; m_busy[i] = 0; end
      reset = 1; ex_ready = 1;
      dec(0, 0, 0, 0, 0, 0, 0);
      wb(0, 0, 0);
      cycle(); cycle();
      reset = 0;
      clear_busy();

      // no hazard read of R3
      wb(1, 3, 16'h1234); cycle(); wb(0, 0, 0);
      dec(1, 3, 1, 0, 1, 0, 0); cycle();
      chk("nohaz_op1", ex_op1, 16'h1234);

      // RAW stall then same-cycle bypass
      dec(1, 0, 0, 0, 0, 1, 5); cycle();
      dec(1, 5, 1, 0, 0, 0, 0); cycle(); cycle();
      chk("raw_stall_cnt", stall_cnt, 2);
      wb(1, 5, 16'hBEEF); cycle(); wb(0, 0, 0);
      chk("raw_bypass_op1", ex_op1, 16'hBEEF);

      // WAW stall released by same-cycle writeback; set wins
      dec(1, 0, 0, 0, 0, 1, 2); cycle();
      dec(1, 0, 0, 0, 0, 1, 2); cycle();
      chk("waw_stall_cnt", stall_cnt, 3);
      wb(1, 2, 16'h5A5A); cycle(); wb(0, 0, 0);
      chk("waw_busy2", dut.u_sb.busy[2], 1);
      clear_busy();

      // backpressure: held bundle stays stable
      dec(1, 1, 1, 1, 1, 0, 0); cycle();
      hold1 = m_op1; hold2 = m_op2;
      ex_ready = 0;
      dec(1, 4, 1, 6, 1, 1, 7);
      repeat (3) begin
         cycle();
         chk("bp_op1", ex_op1, hold1);
         chk("bp_op2", ex_op2, hold2);
      end
      ex_ready = 1; cycle();
      chk("bp_accept_ws", ex_ws, 7);
      dec(0, 0, 0, 0, 0, 0, 0);

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         if (!(dec_valid && !m_acc)) begin
            dec_valid = $urandom_range(0, 3) != 0;
            dec_rs1 = 3'($urandom); dec_rs2 = 3'($urandom);
            dec_use_rs1 = 1'($urandom); dec_use_rs2 = 1'($urandom);
            dec_wr_en = 1'($urandom); dec_ws = 3'($urandom);
         end
         wb(1'($urandom), $urandom, $urandom);
         ex_ready = $urandom_range(0, 3) != 0;
         cycle();
      end
      ex_ready = 1;
      clear_busy();

      // saturation of the stall counter
      dec(1, 0, 0, 0, 0, 1, 5); cycle();
      dec(1, 5, 1, 0, 0, 0, 0);
      repeat (65540) cycle();
      chk("stall_sat", stall_cnt, 16'hFFFF);
      clear_busy();

      // reset mid-stream with all registers pending
      for (int i = 0; i < NREG; i++) begin
         dec(1, 0, 0, 0, 0, 1, i); cycle();
      end
      dec(0, 0, 0, 0, 0, 0, 0);
      chk("busy_full", dut.u_sb.busy, 8'hFF);
      reset = 1; wb(1, 6, 16'hDEAD); cycle();
      reset = 0; wb(0, 0, 0);
      chk("busy_after_reset", dut.u_sb.busy, 8'h00);
      chk("ex_valid_after_reset", ex_valid, 0);
      for (int i = 0; i < NREG; i++) begin
         dec(1, i, 1, 7 - i, 1, 0, 0); cycle();
      end
      dec(0, 0, 0, 0, 0, 0, 0); cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
